k12_result_collector: RTL and testbench
=======================================

# k12_result_collector

Receive-side counterpart to the K12 proof-of-work core's result interface: consumes the core's `store` pulse and 256-bit candidate hash, pairs each result with the nonce that produced it, buffers the pairs in a small FIFO, and streams them to the host link as 32-bit word frames over a valid/ready handshake. Sits between the PoW core and the host transport, one instance per core.

## Interface
- `DEPTH`, default 4, number of buffered results; power of two, ≥2.
- `CNT_W`, default 16, width of the dropped-result counter.

Ports:
- `clk`, in, 1, sole clock; all logic is rising-edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `load`, in, 1, same pulse that starts the PoW core; qualifies `nonce`.
- `nonce`, in, 64, nonce issued to the core with `load`.
- `store`, in, 1, core result strobe, one cycle per passing hash.
- `hash`, in, 256, core candidate hash, valid while `store`=1.
- `tx_data`, out, 32, current frame word.
- `tx_valid`, out, 1, `tx_data` and `tx_last` are valid.
- `tx_ready`, in, 1, host accepts the word when `tx_valid` and `tx_ready` are both 1.
- `tx_last`, out, 1, marks the final word of a frame.
- `fifo_full`, out, 1, all `DEPTH` entries are occupied.
- `drop_count`, out, `CNT_W`, number of results lost to overflow; saturates.

## Operation
- **Nonce tag**
  - When `load`=1, `nonce` is latched into `nonce_tag`.
  - A `store` in the same cycle as `load` uses the old `nonce_tag` value.
- **Push**
  - When `store`=1, the entry {`nonce_tag`, `hash`} (320 bits) is written to the FIFO.
  - If the FIFO is full and no pop completes in the same cycle, the entry is discarded and `drop_count` increments, saturating at all-ones.
  - If the FIFO is full and a pop completes in the same cycle, the push is accepted.
- **Frame**: 10 words, each most-significant word first.
  - Words 0–1: nonce[63:32], nonce[31:0].
  - Words 2–9: hash[255:224] down to hash[31:0].
  - `tx_last` is 1 only on word 9.
- **Transmit FSM**
  - IDLE: if the FIFO is non-empty, load word 0 of the head entry, assert `tx_valid`, go to SEND.
  - SEND: on each handshake, advance the word index (0..9).
    - On the word-9 handshake, pop the head entry.
    - If another entry is present, go straight to its word 0, keeping `tx_valid`=1 with no bubble; otherwise go to IDLE with `tx_valid`=0.
- **Handshake rules**
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data`, `tx_last` and `tx_valid` hold stable.
  - `tx_valid` never deasserts mid-frame.
- **Reset**
  - `rst_n` low clears immediately: FIFO pointers and count, `nonce_tag`, `drop_count`, and the FSM (to IDLE).
  - Output reset values: `tx_valid`=0, `tx_data`=0, `tx_last`=0, `fifo_full`=0, `drop_count`=0.
  - A frame interrupted by reset is abandoned; it is not resent.

## Timing
- All outputs are registered.
- Latency: `store` sampled at edge N into an empty FIFO with the FSM in IDLE gives `tx_valid`=1 and word 0 after edge N+2.
- Throughput: one word per cycle while `tx_ready`=1, i.e. one result per 10 cycles. The core's 13-cycle hash period therefore cannot overflow the FIFO unless the host stalls.
- `fifo_full` updates at the same edge as the FIFO count.
- `drop_count` updates at the edge following the discarded `store`.

## Structure
- Shared package `k12_pkg` holds:
  - `K12_FRAME_WORDS`=10, `K12_WORD_W`=32, `K12_ENTRY_W`=320, `K12_HASH_W`=256, `K12_NONCE_W`=64.
  - The word-index type.
- Sub-module `k12_result_fifo`: synchronous FIFO of width `K12_ENTRY_W` and depth `DEPTH`.
  - Ports: push/pop, head data, full/empty.
  - Pointers are `log2(DEPTH)`+1 bits wide; full/empty come from the wrap bit.
- The collector holds `nonce_tag`, the drop counter, and the transmit FSM with its word mux.

## Test plan
- **Single result.** Stimulus: `load` with nonce=0x0123456789ABCDEF, then `store` with hash=0xFF..FF00..00, `tx_ready`=1. Required: 10 consecutive words 0x01234567, 0x89ABCDEF, then four words 0xFFFFFFFF and four words 0x00000000, with `tx_last` only on the 10th.
- **Backpressure.** Stimulus: `tx_ready` toggled pseudo-randomly during a frame. Required: `tx_data`/`tx_last` stable while stalled, and no word skipped or repeated.
- **Overflow.** Stimulus: `tx_ready`=0, then 6 `store` pulses with `DEPTH`=4. Required: `fifo_full`=1 after the 4th and `drop_count`=2. Then release `tx_ready`: exactly 4 frames, back-to-back with no idle cycle between them.
- **Full with simultaneous pop.** Stimulus: `store` in the same cycle as the word-9 handshake while full. Required: push accepted and `drop_count` unchanged.
- **Load/store coincidence.** Stimulus: `load` with nonce B in the same cycle as `store`, with the tag holding A. Required: the frame carries A; the next `store` carries B.
- **Reset mid-frame.** Stimulus: `rst_n` low at word 5. Required: all outputs go to reset values immediately and no further frames are sent.

Source files
------------

// File: rtl/k12_pkg.sv
// rtl/k12_pkg.sv - shared constants, types and frame word mux for the K12 result collector
package k12_pkg;

    localparam int K12_FRAME_WORDS = 10;
    localparam int K12_WORD_W      = 32;
    localparam int K12_ENTRY_W     = 320;
    localparam int K12_HASH_W      = 256;
    localparam int K12_NONCE_W     = 64;

    typedef logic [3:0] word_idx_t;

    localparam word_idx_t K12_LAST_IDX = word_idx_t'(K12_FRAME_WORDS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    // Entry is {nonce, hash}; word 0 is the most-significant 32 bits.
    function automatic logic [K12_WORD_W-1:0] frame_word(
        input logic [K12_ENTRY_W-1:0] entry,
        input word_idx_t              idx
    );
        logic [K12_ENTRY_W-1:0] shifted;
        shifted    = entry << (K12_WORD_W * int'(idx));
        frame_word = shifted[K12_ENTRY_W-1 -: K12_WORD_W];
    endfunction

endpackage

// File: rtl/k12_result_fifo.sv
// rtl/k12_result_fifo.sv - result entry FIFO with wrap-bit pointers and head/second-entry peek
module k12_result_fifo
    import k12_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [K12_ENTRY_W-1:0] wdata_i,
    output logic [K12_ENTRY_W-1:0] head_o,
    output logic [K12_ENTRY_W-1:0] second_o,
    output logic                   multi_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [K12_ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [AW:0]            rd_next;
    logic [AW:0]            count;
    logic                   push_ok;
    logic                   pop_ok;

    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign multi_o  = (count >= (AW+1)'(2));
    assign rd_next  = rd_ptr_q + (AW+1)'(1);
    assign head_o   = mem_q[rd_ptr_q[AW-1:0]];
    assign second_o = mem_q[rd_next[AW-1:0]];

    // A pop in the same cycle frees the slot being written, so full does not block it.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_ok)  rd_ptr_d = rd_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/k12_result_collector.sv
// rtl/k12_result_collector.sv - pairs PoW results with their nonce, buffers them and streams 10-word frames
module k12_result_collector
    import k12_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [K12_NONCE_W-1:0] nonce,
    input  logic                   store,
    input  logic [K12_HASH_W-1:0]  hash,
    output logic [K12_WORD_W-1:0]  tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    output logic                   fifo_full,
    output logic [CNT_W-1:0]       drop_count
);

    logic [K12_NONCE_W-1:0] nonce_tag_q;
    logic                   stg_valid_q;
    logic [K12_ENTRY_W-1:0] stg_entry_q;
    logic [CNT_W-1:0]       drop_q, drop_d;

    tx_state_e              state_q, state_d;
    word_idx_t              idx_q, idx_d;
    logic                   load_word;
    logic                   use_second;
    logic [K12_WORD_W-1:0]  tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   tx_last_q, tx_last_d;

    logic [K12_ENTRY_W-1:0] head;
    logic [K12_ENTRY_W-1:0] second;
    logic                   multi;
    logic                   full;
    logic                   empty;
    logic                   handshake;
    logic                   pop;
    logic                   drop;

    assign handshake = tx_valid_q && tx_ready;
    assign pop       = handshake && tx_last_q;
    assign drop      = stg_valid_q && full && !pop;
    assign drop_d    = (drop && (drop_q != '1)) ? drop_q + CNT_W'(1) : drop_q;

    k12_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (stg_valid_q),
        .pop_i    (pop),
        .wdata_i  (stg_entry_q),
        .head_o   (head),
        .second_o (second),
        .multi_o  (multi),
        .full_o   (full),
        .empty_o  (empty)
    );

    // The stage captures the tag before a coincident load updates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_tag_q <= '0;
            stg_valid_q <= 1'b0;
            stg_entry_q <= '0;
            drop_q      <= '0;
        end else begin
            stg_valid_q <= store;
            if (store) stg_entry_q <= {nonce_tag_q, hash};
            if (load)  nonce_tag_q <= nonce;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        load_word  = 1'b0;
        use_second = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d   = ST_SEND;
                    idx_d     = '0;
                    load_word = 1'b1;
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    if (idx_q == K12_LAST_IDX) begin
                        // The head is popping this cycle, so the next frame comes from the second slot.
                        if (multi) begin
                            idx_d      = '0;
                            load_word  = 1'b1;
                            use_second = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d     = idx_q + word_idx_t'(1);
                        load_word = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid_d = (state_d == ST_SEND);
        tx_data_d  = tx_data_q;
        tx_last_d  = tx_last_q;
        if (load_word) begin
            tx_data_d = frame_word(use_second ? second : head, idx_d);
            tx_last_d = (idx_d == K12_LAST_IDX);
        end else if (state_d == ST_IDLE) begin
            tx_data_d = '0;
            tx_last_d = 1'b0;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign tx_last    = tx_last_q;
    assign fifo_full  = full;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_k12_result_collector.sv
// tb/tb_k12_result_collector.sv - scoreboard bench for k12_result_collector
module tb_k12_result_collector;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load;
    logic [63:0]       nonce;
    logic              store;
    logic [255:0]      hash;
    logic [31:0]       tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;
    logic              fifo_full;
    logic [CNT_W-1:0]  drop_count;

    k12_result_collector #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .nonce      (nonce),
        .store      (store),
        .hash       (hash),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last),
        .fifo_full  (fifo_full),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];
    logic [63:0] tb_tag = '0;
    int          gap_cnt = 0;
    int          frame_cnt = 0;
    int          valid_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [63:0] n, input logic [255:0] h);
        logic [319:0] entry;
        entry = {n, h};
        for (int i = 0; i < 10; i++)
            exp_q.push_back({(i == 9), entry[319 - 32*i -: 32]});
    endtask

    function automatic logic [255:0] rand_hash();
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
        return h;
    endfunction

    task automatic do_load(input logic [63:0] n);
        load  = 1'b1;
        nonce = n;
        tick();
        load   = 1'b0;
        tb_tag = n;
    endtask

    task automatic do_store(input logic [255:0] h, input logic accept);
        store = 1'b1;
        hash  = h;
        if (accept) push_frame(tb_tag, h);
        tick();
        store = 1'b0;
    endtask

    task automatic drain(input int max_cycles, input logic rand_ready);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < max_cycles) begin
            if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    // Word monitor: compares every handshake against the scoreboard and checks stall stability.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(tx_valid), 64'd1);
                check("hold_data", 64'(tx_data), 64'(prev_data));
                check("hold_last", 64'(tx_last), 64'(prev_last));
            end
            if (tx_valid) valid_cnt++;
            else if (exp_q.size() != 0) gap_cnt++;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", 64'(tx_data), 64'(e[31:0]));
                    check("word_last", 64'(tx_last), 64'(e[32]));
                    if (tx_last) frame_cnt++;
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
        end
    end

    initial begin
        logic [255:0] h1;
        logic         found;

        rst_n    = 1'b0;
        load     = 1'b0;
        nonce    = '0;
        store    = 1'b0;
        hash     = '0;
        tx_ready = 1'b0;
        repeat (2) tick();
        check("rst_valid", 64'(tx_valid), 64'd0);
        check("rst_data", 64'(tx_data), 64'd0);
        check("rst_last", 64'(tx_last), 64'd0);
        check("rst_full", 64'(fifo_full), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single result with latency check
        tx_ready = 1'b1;
        do_load(64'h0123456789ABCDEF);
        store = 1'b1;
        hash  = {{128{1'b1}}, {128{1'b0}}};
        push_frame(tb_tag, hash);
        tick();
        store = 1'b0;
        check("lat_n", 64'(tx_valid), 64'd0);
        tick();
        check("lat_n1", 64'(tx_valid), 64'd0);
        tick();
        check("lat_n2_valid", 64'(tx_valid), 64'd1);
        check("lat_n2_word0", 64'(tx_data), 64'h01234567);
        drain(40, 1'b0);

        // Backpressure
        do_load(64'hDEADBEEF_CAFEF00D);
        do_store(rand_hash(), 1'b1);
        do_store(rand_hash(), 1'b1);
        drain(300, 1'b1);
        tx_ready = 1'b1;
        repeat (3) tick();

        // Overflow
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            do_store(rand_hash(), (i < 4));
            if (i == 3) check("not_full_at3", 64'(fifo_full), 64'd0);
            if (i == 4) check("full_after4", 64'(fifo_full), 64'd1);
        end
        repeat (2) tick();
        check("ovf_full", 64'(fifo_full), 64'd1);
        check("ovf_drop", 64'(drop_count), 64'd2);
        gap_cnt   = 0;
        frame_cnt = 0;
        tx_ready  = 1'b1;
        drain(100, 1'b0);
        check("b2b_gaps", 64'(gap_cnt), 64'd0);
        check("b2b_frames", 64'(frame_cnt), 64'd4);
        check("empty_after", 64'(tx_valid), 64'd0);

        // Full with simultaneous pop
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_store(rand_hash(), 1'b1);
        repeat (3) tick();
        check("fp_full", 64'(fifo_full), 64'd1);
        tx_ready = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (tx_valid && tx_last) found = 1'b1;
        end
        check("fp_find_last", 64'(found), 64'd1);
        tx_ready = 1'b0;
        h1    = rand_hash();
        store = 1'b1;
        hash  = h1;
        push_frame(tb_tag, h1);
        tick();
        store    = 1'b0;
        tx_ready = 1'b1;
        tick();
        check("fp_still_full", 64'(fifo_full), 64'd1);
        check("fp_drop_same", 64'(drop_count), 64'd2);
        drain(100, 1'b0);

        // Load/store coincidence
        load  = 1'b1;
        nonce = 64'hBBBB_0000_1111_BBBB;
        store = 1'b1;
        hash  = rand_hash();
        push_frame(tb_tag, hash);
        tick();
        load   = 1'b0;
        store  = 1'b0;
        tb_tag = 64'hBBBB_0000_1111_BBBB;
        do_store(rand_hash(), 1'b1);
        drain(60, 1'b0);

        // Reset mid-frame
        tx_ready = 1'b0;
        do_store(rand_hash(), 1'b1);
        do_store(rand_hash(), 1'b1);
        repeat (2) tick();
        check("rm_valid", 64'(tx_valid), 64'd1);
        tx_ready = 1'b1;
        repeat (5) tick();
        check("rm_word5", 64'(tx_data), 64'(exp_q[0][31:0]));
        #2;
        rst_n    = 1'b0;
        tx_ready = 1'b0;
        #1;
        check("rm_valid0", 64'(tx_valid), 64'd0);
        check("rm_data0", 64'(tx_data), 64'd0);
        check("rm_last0", 64'(tx_last), 64'd0);
        check("rm_full0", 64'(fifo_full), 64'd0);
        check("rm_drop0", 64'(drop_count), 64'd0);
        exp_q.delete();
        repeat (2) tick();
        rst_n     = 1'b1;
        valid_cnt = 0;
        tx_ready  = 1'b1;
        repeat (40) tick();
        check("rm_no_resend", 64'(valid_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
